instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Write-side companion to the instruction ROM. It receives a program as a byte stream from the debug UART receiver and assembles each group of four bytes into a 32-bit instruction.
- Each instruction is written sequentially into the instruction BRAM write port, starting at word 0.
- Loading stops on a HALT instruction, on memory full, or on an inter-byte timeout.
- The MIPS core is held off by the debug unit until o_done.

Parameters:
- RAM_WIDTH, 32, instruction width; must be 32.
- RAM_DEPTH, 2048, number of instruction words.
- ADDR_W, clogb2(RAM_DEPTH-1), word address width.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker; it is itself written to memory.
- TIMEOUT_CYCLES, 1000000, maximum clka cycles between bytes of a partially received word.

Ports:
- clka  in  1  clock, rising edge.
- rsta_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse: begin a new load at word 0.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe: i_rx_data is valid.
- o_wea  out  1  BRAM write enable, one-cycle pulse per word.
- o_addra  out  ADDR_W  BRAM word address.
- o_dina  out  32  BRAM write data.
- o_busy  out  1  high in LOAD.
- o_done  out  1  high in DONE.
- o_full  out  1  load ended at RAM_DEPTH words without HALT.
- o_error  out  1  high in ERROR (timeout).
- o_word_count  out  ADDR_W+1  words written in the current load.

Behaviour:
- Reset (async, rsta_n low): state IDLE; all outputs 0; byte counter, word index, shift register and timeout counter cleared.
- All outputs are registered at the clka rising edge. BRAM samples on negedge, so o_addra/o_dina are stable for the full o_wea cycle.
- States: IDLE, LOAD, DONE, ERROR.
- IDLE:
  - i_start -> LOAD; clear word index, byte count, o_word_count, o_full, o_error.
  - Bytes arriving in IDLE are ignored.
- LOAD, byte assembly:
  - Bytes are big-endian: the first byte of a word goes to [31:24].
  - On i_rx_valid, shift the byte in and increment byte count (0..3).
  - On the 4th byte (accepted in cycle N), in cycle N+1: o_wea=1, o_dina=word, o_addra=word index.
  - At the end of cycle N+1, o_word_count and word index increment.
- LOAD, exits (both taken in the same cycle as the write):
  - Assembled word == HALT_WORD -> DONE.
  - Else, word index == RAM_DEPTH-1 -> DONE with o_full=1.
- LOAD, timeout:
  - The timeout counter runs only while byte count != 0. It resets on every accepted byte.
  - When it reaches TIMEOUT_CYCLES -> ERROR; the partial word is discarded and not written.
- i_start while in LOAD is ignored.
- Simultaneous i_rx_valid and i_start in IDLE/DONE/ERROR: start wins and the byte is dropped.
- DONE and ERROR:
  - Hold flags and o_word_count; bytes are ignored.
  - i_start -> LOAD, restarting at word 0 and clearing flags.
- o_wea is never high outside the single write cycle.
- Reset mid-load aborts immediately. BRAM contents are unaffected beyond words already written.

Decomposition:
- Shared package (mips_pkg): HALT_WORD, state encoding localparams, and the clogb2 function shared with the instruction ROM.
- One natural sub-module: loader_timeout_counter, a loadable down-counter with expiry flag.

Test Plan:
- Reset release, then bytes 00 00 00 01 without i_start -> o_wea never asserts; state stays IDLE.
- i_start, then bytes 20 08 00 05 | FF FF FF FF ->
  - o_wea cycle with addra 0, dina 32'h20080005;
  - o_wea cycle with addra 1, dina 32'hFFFFFFFF;
  - then o_done=1, o_word_count=2, o_full=0.
- RAM_DEPTH=4, i_start, 16 bytes with no HALT -> 4 writes to addra 0..3; o_done=1, o_full=1; a 17th byte produces no o_wea.
- TIMEOUT_CYCLES=50, i_start, 2 bytes, then idle 50 cycles -> o_error=1, no write; then i_start plus 4 bytes AA BB CC DD -> write addra 0, dina 32'hAABBCCDD.
- Back-to-back i_rx_valid every cycle for 8 bytes -> two o_wea pulses exactly 4 cycles apart at addra 0 and 1.
- rsta_n pulsed low after 2 bytes of word 3 -> all outputs 0 asynchronously; subsequent i_start reloads from addra 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the instruction ROM and its write-side loader.
package mips_pkg;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } loader_state_e;

   // Number of bits needed to hold the given value (address width for depth-1).
   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned v;
      int unsigned bits;
      v    = value;
      bits = 0;
      while (v > 0) begin
         v    = v >> 1;
         bits = bits + 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// Inter-byte watchdog: reloads on every accepted byte, counts down while enabled.
module loader_timeout_counter
   import mips_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expired_c
);

   localparam int unsigned     CNT_W  = clogb2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= RELOAD;
      end else if (en && (count_q != '0)) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign expired_c = (count_q == '0);

endmodule

// File: rtl/instr_mem_loader.sv
// Assembles a big-endian UART byte stream into 32-bit words and writes them to the instruction BRAM.
module instr_mem_loader
   import mips_pkg::*;
#(
   parameter int unsigned RAM_WIDTH      = 32,
   parameter int unsigned RAM_DEPTH      = 2048,
   parameter int unsigned ADDR_W         = clogb2(RAM_DEPTH - 1),
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                 clka,
   input  logic                 rsta_n,
   input  logic                 i_start,
   input  logic [7:0]           i_rx_data,
   input  logic                 i_rx_valid,
   output logic                 o_wea,
   output logic [ADDR_W-1:0]    o_addra,
   output logic [RAM_WIDTH-1:0] o_dina,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_full,
   output logic                 o_error,
   output logic [ADDR_W:0]      o_word_count
);

   localparam int unsigned SHIFT_W = RAM_WIDTH - 8;

   loader_state_e        state_q, state_d;
   logic [1:0]           byte_cnt_q, byte_cnt_d;
   logic [SHIFT_W-1:0]   shift_q, shift_d;
   logic [ADDR_W-1:0]    word_idx_q, word_idx_d;
   logic                 wea_d, busy_d, done_d, full_d, error_d;
   logic [ADDR_W-1:0]    addra_d;
   logic [RAM_WIDTH-1:0] dina_d;
   logic [ADDR_W:0]      word_count_d;
   logic                 byte_accept_c;
   logic                 tmo_run_c;
   logic                 tmo_expired_c;

   assign tmo_run_c = (state_q == ST_LOAD) && (byte_cnt_q != 2'd0);

   loader_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clka),
      .rst_n     (rsta_n),
      .load      (byte_accept_c),
      .en        (tmo_run_c),
      .expired_c (tmo_expired_c)
   );

   // Next state and next registered outputs.
   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      shift_d       = shift_q;
      word_idx_d    = word_idx_q;
      wea_d         = 1'b0;
      addra_d       = o_addra;
      dina_d        = o_dina;
      word_count_d  = o_word_count;
      full_d        = o_full;
      error_d       = o_error;
      byte_accept_c = 1'b0;

      case (state_q)
         ST_LOAD: begin
            // Write cycle: advance the index and decide whether the load ends here.
            if (o_wea) begin
               word_idx_d   = word_idx_q + ADDR_W'(1);
               word_count_d = o_word_count + (ADDR_W + 1)'(1);
               if (o_dina == HALT_WORD) begin
                  state_d = ST_DONE;
               end else if (word_idx_q == ADDR_W'(RAM_DEPTH - 1)) begin
                  state_d = ST_DONE;
                  full_d  = 1'b1;
               end
            end
            if (state_d == ST_LOAD) begin
               if (i_rx_valid) begin
                  byte_accept_c = 1'b1;
                  byte_cnt_d    = byte_cnt_q + 2'd1;
                  shift_d       = {shift_q[SHIFT_W-9:0], i_rx_data};
                  if (byte_cnt_q == 2'd3) begin
                     wea_d   = 1'b1;
                     addra_d = word_idx_q;
                     dina_d  = {shift_q, i_rx_data};
                  end
               end else if (tmo_run_c && tmo_expired_c) begin
                  state_d    = ST_ERROR;
                  error_d    = 1'b1;
                  byte_cnt_d = 2'd0;
                  shift_d    = '0;
               end
            end
         end
         default: begin
            if (i_start) begin
               state_d      = ST_LOAD;
               byte_cnt_d   = 2'd0;
               shift_d      = '0;
               word_idx_d   = '0;
               word_count_d = '0;
               full_d       = 1'b0;
               error_d      = 1'b0;
            end
         end
      endcase

      busy_d = (state_d == ST_LOAD);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_q      <= ST_IDLE;
         byte_cnt_q   <= 2'd0;
         shift_q      <= '0;
         word_idx_q   <= '0;
         o_wea        <= 1'b0;
         o_addra      <= '0;
         o_dina       <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_full       <= 1'b0;
         o_error      <= 1'b0;
         o_word_count <= '0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         shift_q      <= shift_d;
         word_idx_q   <= word_idx_d;
         o_wea        <= wea_d;
         o_addra      <= addra_d;
         o_dina       <= dina_d;
         o_busy       <= busy_d;
         o_done       <= done_d;
         o_full       <= full_d;
         o_error      <= error_d;
         o_word_count <= word_count_d;
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader with a 4-word RAM and a 50-cycle inter-byte timeout.
module tb_instr_mem_loader;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;
   localparam int unsigned TMO   = 50;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      int            cyc;
   } obs_t;

   logic          clka = 1'b0;
   logic          rsta_n = 1'b1;
   logic          i_start;
   logic [7:0]    i_rx_data;
   logic          i_rx_valid;
   logic          o_wea;
   logic [AW-1:0] o_addra;
   logic [31:0]   o_dina;
   logic          o_busy;
   logic          o_done;
   logic          o_full;
   logic          o_error;
   logic [AW:0]   o_word_count;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   obs_rd   = 0;
   wr_t  exp_q[$];
   obs_t obs_q[$];

   instr_mem_loader #(
      .RAM_WIDTH      (32),
      .RAM_DEPTH      (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clka         (clka),
      .rsta_n       (rsta_n),
      .i_start      (i_start),
      .i_rx_data    (i_rx_data),
      .i_rx_valid   (i_rx_valid),
      .o_wea        (o_wea),
      .o_addra      (o_addra),
      .o_dina       (o_dina),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_full       (o_full),
      .o_error      (o_error),
      .o_word_count (o_word_count)
   );

   always #5 clka = ~clka;

   always @(posedge clka) cyc <= cyc + 1;

   // Capture every BRAM write mid-cycle, away from the active edge.
   always @(negedge clka) begin
      if (rsta_n && o_wea) obs_q.push_back('{addr: o_addra, data: o_dina, cyc: cyc});
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clka);
      #1;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick(1);
      i_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      tick(1);
      i_rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 3; i >= 0; i--) begin
         send_byte(w[8*i +: 8]);
         if (gap > 0) tick(gap);
      end
   endtask

   task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
      exp_q.push_back('{addr: a, data: d});
   endtask

   // Pop expected writes against every observed write not yet compared.
   task automatic drain();
      wr_t e;
      while (obs_rd < obs_q.size()) begin
         check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(obs_q[obs_rd].addr), 64'(e.addr));
            check("wr_data", 64'(obs_q[obs_rd].data), 64'(e.data));
         end
         obs_rd++;
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({o_wea, o_addra, o_dina, o_busy, o_done, o_full, o_error, o_word_count});
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int base;
      logic [31:0] w;
      i_start    = 1'b0;
      i_rx_data  = 8'h00;
      i_rx_valid = 1'b0;

      // Reset state
      #2 rsta_n = 1'b0;
      #10;
      check("reset_outs", all_outs(), 64'd0);
      @(posedge clka);
      #1 rsta_n = 1'b1;
      tick(1);

      // Bytes in IDLE are ignored
      send_word(32'h0000_0001, 0);
      tick(2);
      check("idle_busy", 64'(o_busy), 64'd0);
      check("idle_no_write", 64'(obs_q.size()), 64'd0);

      // Two-word program ending on HALT
      pulse_start();
      check("load_busy", 64'(o_busy), 64'd1);
      expect_wr(2'd0, 32'h2008_0005);
      expect_wr(2'd1, 32'hFFFF_FFFF);
      send_word(32'h2008_0005, 1);
      send_word(32'hFFFF_FFFF, 1);
      tick(3);
      drain();
      check("halt_done", 64'(o_done), 64'd1);
      check("halt_busy", 64'(o_busy), 64'd0);
      check("halt_count", 64'(o_word_count), 64'd2);
      check("halt_full", 64'(o_full), 64'd0);

      // Memory full without HALT, then a stray byte
      pulse_start();
      check("restart_count", 64'(o_word_count), 64'd0);
      check("restart_done", 64'(o_done), 64'd0);
      for (int i = 0; i < 4; i++) begin
         w = 32'h0102_0304 + 32'(i) * 32'h0404_0404;
         expect_wr(AW'(i), w);
         send_word(w, 0);
      end
      tick(3);
      drain();
      check("full_done", 64'(o_done), 64'd1);
      check("full_flag", 64'(o_full), 64'd1);
      check("full_count", 64'(o_word_count), 64'd4);
      base = obs_q.size();
      send_byte(8'h55);
      tick(3);
      check("full_stray_no_write", 64'(obs_q.size()), 64'(base));
      check("full_hold_count", 64'(o_word_count), 64'd4);

      // Inter-byte timeout discards the partial word
      pulse_start();
      check("tmo_flags_clear", 64'({o_full, o_done}), 64'd0);
      base = obs_q.size();
      send_byte(8'h12);
      send_byte(8'h34);
      tick(TMO - 1);
      check("tmo_not_yet", 64'(o_error), 64'd0);
      tick(1);
      check("tmo_error", 64'(o_error), 64'd1);
      check("tmo_busy", 64'(o_busy), 64'd0);
      check("tmo_no_write", 64'(obs_q.size()), 64'(base));

      // Restart after error
      pulse_start();
      check("err_cleared", 64'(o_error), 64'd0);
      expect_wr(2'd0, 32'hAABB_CCDD);
      send_word(32'hAABB_CCDD, 0);
      tick(2);
      drain();
      check("err_restart_count", 64'(o_word_count), 64'd1);

      // i_start during LOAD is ignored; back-to-back bytes give writes 4 cycles apart
      pulse_start();
      check("start_in_load_count", 64'(o_word_count), 64'd1);
      base = obs_q.size();
      expect_wr(2'd1, 32'h1111_2222);
      expect_wr(2'd2, 32'h3333_4444);
      send_word(32'h1111_2222, 0);
      send_word(32'h3333_4444, 0);
      tick(2);
      check("b2b_writes", 64'(obs_q.size() - base), 64'd2);
      if (obs_q.size() - base == 2)
         check("b2b_spacing", 64'(obs_q[base+1].cyc - obs_q[base].cyc), 64'd4);
      drain();

      // HALT in the last word ends as done, not full
      expect_wr(2'd3, 32'hFFFF_FFFF);
      send_word(32'hFFFF_FFFF, 0);
      tick(3);
      drain();
      check("halt_last_done", 64'(o_done), 64'd1);
      check("halt_last_full", 64'(o_full), 64'd0);
      check("halt_last_count", 64'(o_word_count), 64'd4);

      // Asynchronous reset mid-word, then reload from word 0
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         w = 32'hC0DE_0000 + 32'(i);
         expect_wr(AW'(i), w);
         send_word(w, 1);
      end
      send_byte(8'hDE);
      send_byte(8'hAD);
      drain();
      rsta_n = 1'b0;
      #2;
      check("midload_reset_outs", all_outs(), 64'd0);
      @(posedge clka);
      #1 rsta_n = 1'b1;
      tick(1);
      pulse_start();
      expect_wr(2'd0, 32'h1234_5678);
      send_word(32'h1234_5678, 0);
      tick(2);
      drain();
      check("reload_count", 64'(o_word_count), 64'd1);
      check("reload_busy", 64'(o_busy), 64'd1);

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
